comparador_sequencial: RTL and testbench
========================================

COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the bits per digit.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the digits per code.
REQ-003 The block SHALL have parameter MAX_TRIES, default 3, giving the failed entries allowed before lockout.
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 16, giving the lockout duration in clock cycles.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-008 Port load_valid SHALL be an input, 1 bit wide: it presents one stored-code digit on load_data.
REQ-009 Port load_data SHALL be an input, WIDTH bits wide: the stored-code digit.
REQ-010 Port digit_valid SHALL be an input, 1 bit wide: it presents one entered digit on digit.
REQ-011 Port digit SHALL be an input, WIDTH bits wide: the entered digit.
REQ-012 Port clear SHALL be an input, 1 bit wide: it abandons a partial entry.
REQ-013 Port reprog SHALL be an input, 1 bit wide: it requests return to code loading.
REQ-014 Port ready SHALL be an output, 1 bit wide: high when digits are accepted.
REQ-015 Port match SHALL be an output, 1 bit wide: a one-cycle pulse on a correct full entry.
REQ-016 Port fail SHALL be an output, 1 bit wide: a one-cycle pulse on a wrong full entry.
REQ-017 Port locked SHALL be an output, 1 bit wide: high during lockout.
REQ-018 Port tries_left SHALL be an output, $clog2(MAX_TRIES+1) bits wide: the remaining attempts.
REQ-019 Port entry_count SHALL be an output, $clog2(DEPTH+1) bits wide: the digits accepted in the current load or entry.

Function
REQ-020 The FSM SHALL have exactly three states: LOAD, ARMED and LOCK.
REQ-021 In LOAD, each cycle with load_valid=1 SHALL write load_data into code[entry_count] and increment entry_count.
REQ-022 When the DEPTH-th digit is written, the FSM SHALL enter ARMED and set entry_count to 0 on the same edge.
REQ-023 In ARMED, each cycle with digit_valid=1 SHALL compare digit to code[entry_count] bitwise (XNOR of all bits, AND-reduced), increment entry_count, and OR any mismatch into a sticky error flag.
REQ-024 On the edge accepting the DEPTH-th digit with no error, the block SHALL pulse match for exactly the following cycle, reload tries_left to MAX_TRIES, clear entry_count and the error flag, and stay in ARMED.
REQ-025 On the same edge with the error set, the block SHALL pulse fail for exactly the following cycle and decrement tries_left.
REQ-026 If that decrement makes tries_left 0, the FSM SHALL enter LOCK; otherwise it SHALL stay in ARMED with entry_count and the error flag cleared.
REQ-027 Error detection SHALL only be reported after DEPTH digits; no early fail on the first mismatching digit.
REQ-028 In LOCK, locked SHALL be 1 for exactly LOCK_CYCLES cycles; the FSM SHALL then enter ARMED with tries_left=MAX_TRIES and entry_count=0.
REQ-029 ready SHALL be 1 in LOAD and ARMED and 0 in LOCK.
REQ-030 Any input other than rst_n SHALL be ignored in LOCK.
REQ-031 clear in ARMED SHALL zero entry_count and the error flag without consuming a try.
REQ-032 clear in LOAD SHALL zero entry_count and keep the code contents.
REQ-033 If clear and digit_valid are high in the same cycle, clear SHALL win and the digit SHALL be discarded.
REQ-034 reprog in ARMED SHALL enter LOAD with entry_count=0, and the tries_left count SHALL be kept.
REQ-035 If reprog coincides with the final digit, reprog SHALL win: no match or fail pulse, and no try consumed.
REQ-036 load_valid outside LOAD and digit_valid outside ARMED SHALL have no effect.
REQ-037 match and fail SHALL be registered outputs and SHALL never be high in the same cycle.

Reset
REQ-038 While rst_n=0, the block SHALL immediately force state=LOAD, entry_count=0, error flag=0, match=0, fail=0, locked=0, tries_left=MAX_TRIES, every code[] entry=0 and the lock counter=0, so that ready=1.
REQ-039 Reset asserted mid-entry or mid-lockout SHALL abort it, with no pulse emitted on release.

Verification (defaults)
REQ-040 The bench SHALL load 5,2,7,1, then enter 5,2,7,1 -> entry_count goes 1..3 then 0, match=1 for one cycle, and tries_left=3.
REQ-041 The bench SHALL enter 5,2,0,1 three times -> fail pulses with tries_left 2,1,0, then locked=1 and ready=0 for 16 cycles, then ARMED with tries_left=3.
REQ-042 During lockout, the bench SHALL drive digits 5,2,7,1 -> no match and entry_count stays 0.
REQ-043 The bench SHALL enter 5,2, then assert clear together with digit 7, then enter 5,2,7,1 -> a single match and tries_left unchanged.
REQ-044 After one failed entry (tries_left=2), the bench SHALL assert reprog, load 0,0,0,0, then enter 0,0,0,0 -> match, with tries_left 2 during load and 3 after the match.
REQ-045 The bench SHALL pull rst_n low after two entered digits -> all outputs take their reset values without waiting for a clock edge, and entering 0,0,0,0 after release does nothing until 4 load digits are accepted.

Source files
------------

// File: rtl/comparador_sequencial.sv
// Sequential code comparator (digital lock).
// A DEPTH-digit code is loaded digit by digit, then entered digits are
// compared against it. A wrong full entry consumes a try; running out of
// tries locks the block for LOCK_CYCLES cycles.
//
// Handshake: load_valid and digit_valid are single-cycle qualifiers sampled on
// each rising clk edge; a digit is consumed on every edge where its valid is
// high and ready is high in the matching state (LOAD for load_valid, ARMED for
// digit_valid). There is no back-pressure beyond ready; inputs offered while
// ready is low, or in the wrong state, are dropped.
module comparador_sequencial #(
  parameter int WIDTH       = 3,
  parameter int DEPTH       = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_valid,
  input  logic [WIDTH-1:0]               load_data,
  input  logic                           digit_valid,
  input  logic [WIDTH-1:0]               digit,
  input  logic                           clear,
  input  logic                           reprog,
  output logic                           ready,
  output logic                           match,
  output logic                           fail,
  output logic                           locked,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
  output logic [$clog2(DEPTH+1)-1:0]     entry_count,
  output logic [1:0]                     dbg_state
);

  localparam int TW  = $clog2(MAX_TRIES+1);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ARMED = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] code [DEPTH];
  logic             err;
  logic [LCW-1:0]   lock_cnt;

  logic [IW-1:0]    idx;
  logic             last_digit;
  logic             digit_hit;
  logic             err_next;

  // Current digit position, compare of the entered digit, and sticky error.
  assign idx        = entry_count[IW-1:0];
  assign last_digit = (entry_count == CW'(DEPTH-1));
  assign digit_hit  = &(digit ~^ code[idx]);
  assign err_next   = err | ~digit_hit;
  assign dbg_state  = state;

  // Lock FSM with all outputs registered; match/fail default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      entry_count <= '0;
      err         <= 1'b0;
      match       <= 1'b0;
      fail        <= 1'b0;
      locked      <= 1'b0;
      ready       <= 1'b1;
      tries_left  <= TW'(MAX_TRIES);
      lock_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) code[i] <= '0;
    end else begin
      match <= 1'b0;
      fail  <= 1'b0;
      case (state)
        LOAD: begin
          if (clear) begin
            entry_count <= '0;
          end else if (load_valid) begin
            code[idx] <= load_data;
            if (last_digit) begin
              state       <= ARMED;
              entry_count <= '0;
              err         <= 1'b0;
            end else begin
              entry_count <= entry_count + CW'(1);
            end
          end
        end
        ARMED: begin
          // reprog beats clear, which beats a digit in the same cycle.
          if (reprog) begin
            state       <= LOAD;
            entry_count <= '0;
            err         <= 1'b0;
          end else if (clear) begin
            entry_count <= '0;
            err         <= 1'b0;
          end else if (digit_valid) begin
            if (last_digit) begin
              entry_count <= '0;
              err         <= 1'b0;
              if (!err_next) begin
                match      <= 1'b1;
                tries_left <= TW'(MAX_TRIES);
              end else begin
                fail       <= 1'b1;
                tries_left <= tries_left - TW'(1);
                if (tries_left == TW'(1)) begin
                  state    <= LOCK;
                  locked   <= 1'b1;
                  ready    <= 1'b0;
                  lock_cnt <= '0;
                end
              end
            end else begin
              entry_count <= entry_count + CW'(1);
              err         <= err_next;
            end
          end
        end
        LOCK: begin
          if (lock_cnt == LCW'(LOCK_CYCLES-1)) begin
            state       <= ARMED;
            locked      <= 1'b0;
            ready       <= 1'b1;
            tries_left  <= TW'(MAX_TRIES);
            entry_count <= '0;
            err         <= 1'b0;
            lock_cnt    <= '0;
          end else begin
            lock_cnt <= lock_cnt + LCW'(1);
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_sequencial.sv
// Bench for comparador_sequencial at default parameters.
// Expected match/fail pulses (with tries_left) are queued by the stimulus and
// popped by an independent monitor whenever match or fail is seen.
module tb_comparador_sequencial;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic [2:0] load_data;
  logic       digit_valid;
  logic [2:0] digit;
  logic       clear;
  logic       reprog;
  logic       ready;
  logic       match;
  logic       fail;
  logic       locked;
  logic [1:0] tries_left;
  logic [2:0] entry_count;
  logic [1:0] dbg_state;

  // {is_match, tries_left after the pulse}
  logic [2:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  comparador_sequencial dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .reprog      (reprog),
    .ready       (ready),
    .match       (match),
    .fail        (fail),
    .locked      (locked),
    .tries_left  (tries_left),
    .entry_count (entry_count),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && (match || fail)) begin
      check("match_fail_exclusive", {31'd0, match & fail}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got match=%0b fail=%0b tries_left=%0d, expected no pulse (t=%0t)",
                 match, fail, tries_left, $time);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check("pulse", {29'd0, match, tries_left}, {29'd0, e});
      end
    end
  end

  // Driver tasks: inputs change just after a negedge, outputs checked at the next.
  task automatic idle();
    load_valid  = 1'b0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    reprog      = 1'b0;
  endtask

  task automatic load_digit(input logic [2:0] d);
    load_valid = 1'b1;
    load_data  = d;
    @(negedge clk);
    idle();
  endtask

  task automatic enter_digit(input logic [2:0] d);
    digit_valid = 1'b1;
    digit       = d;
    @(negedge clk);
    idle();
  endtask

  task automatic load4(input logic [11:0] v);
    for (int i = 0; i < 4; i++) begin
      load_digit(v[11-3*i -: 3]);
      check("load_entry_count", {29'd0, entry_count}, (i == 3) ? 0 : i + 1);
    end
    check("armed_after_load", {30'd0, dbg_state}, 32'd1);
  endtask

  task automatic enter4(input logic [11:0] v, input bit pulse, input logic [2:0] item);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && pulse) exp_q.push_back(item);
      enter_digit(v[11-3*i -: 3]);
      check("entry_count", {29'd0, entry_count}, (i == 3) ? 0 : i + 1);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    idle();
    load_data = '0;
    digit     = '0;

    // Reset values
    rst_n = 1'b0;
    #12;
    check("rst_ready",  {31'd0, ready},       32'd1);
    check("rst_match",  {31'd0, match},       32'd0);
    check("rst_fail",   {31'd0, fail},        32'd0);
    check("rst_locked", {31'd0, locked},      32'd0);
    check("rst_tries",  {30'd0, tries_left},  32'd3);
    check("rst_count",  {29'd0, entry_count}, 32'd0);
    check("rst_state",  {30'd0, dbg_state},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load 5,2,7,1 then enter it correctly
    load4({3'd5, 3'd2, 3'd7, 3'd1});
    enter4({3'd5, 3'd2, 3'd7, 3'd1}, 1'b1, {1'b1, 2'd3});
    check("tries_after_match", {30'd0, tries_left}, 32'd3);

    // Three wrong entries -> lockout
    enter4({3'd5, 3'd2, 3'd0, 3'd1}, 1'b1, {1'b0, 2'd2});
    enter4({3'd5, 3'd2, 3'd0, 3'd1}, 1'b1, {1'b0, 2'd1});
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({1'b0, 2'd0});
      enter_digit((i == 0) ? 3'd5 : (i == 1) ? 3'd2 : (i == 2) ? 3'd0 : 3'd1);
    end
    check("lock_locked", {31'd0, locked},     32'd1);
    check("lock_ready",  {31'd0, ready},      32'd0);
    check("lock_tries",  {30'd0, tries_left}, 32'd0);
    cnt = 1;

    // Correct code during lockout must be ignored
    for (int i = 0; i < 4; i++) begin
      enter_digit((i == 0) ? 3'd5 : (i == 1) ? 3'd2 : (i == 2) ? 3'd7 : 3'd1);
      check("lock_entry_count", {29'd0, entry_count}, 32'd0);
      if (locked) cnt++;
    end
    guard = 0;
    while (locked && guard < 40) begin
      @(negedge clk);
      guard++;
      if (locked) cnt++;
    end
    check("lock_cycles",       cnt,                      32'd16);
    check("unlock_ready",      {31'd0, ready},           32'd1);
    check("unlock_tries",      {30'd0, tries_left},      32'd3);
    check("unlock_state",      {30'd0, dbg_state},       32'd1);
    check("unlock_entry",      {29'd0, entry_count},     32'd0);

    // Partial entry, clear wins over a coincident digit, then full entry
    enter_digit(3'd5);
    enter_digit(3'd2);
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit       = 3'd7;
    @(negedge clk);
    idle();
    check("clear_entry", {29'd0, entry_count}, 32'd0);
    enter4({3'd5, 3'd2, 3'd7, 3'd1}, 1'b1, {1'b1, 2'd3});
    check("clear_tries", {30'd0, tries_left}, 32'd3);

    // One failure, reprog keeps tries, load 0000, enter 0000
    enter4({3'd5, 3'd2, 3'd0, 3'd1}, 1'b1, {1'b0, 2'd2});
    reprog = 1'b1;
    @(negedge clk);
    idle();
    check("reprog_state", {30'd0, dbg_state},   32'd0);
    check("reprog_entry", {29'd0, entry_count}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      load_digit(3'd0);
      check("reload_tries", {30'd0, tries_left}, 32'd2);
    end
    check("reload_state", {30'd0, dbg_state}, 32'd1);
    enter4(12'd0, 1'b1, {1'b1, 2'd3});
    check("reload_match_tries", {30'd0, tries_left}, 32'd3);

    // reprog together with the final digit: no pulse, no try consumed
    enter_digit(3'd0);
    enter_digit(3'd0);
    enter_digit(3'd0);
    reprog      = 1'b1;
    digit_valid = 1'b1;
    digit       = 3'd0;
    @(negedge clk);
    idle();
    check("reprog_last_state", {30'd0, dbg_state},  32'd0);
    check("reprog_last_tries", {30'd0, tries_left}, 32'd3);

    // clear in LOAD restarts the load position
    load_digit(3'd6);
    load_digit(3'd6);
    clear = 1'b1;
    @(negedge clk);
    idle();
    check("load_clear_entry", {29'd0, entry_count}, 32'd0);
    load4(12'd0);

    // Fail once, then reset mid-entry
    enter4({3'd1, 3'd1, 3'd1, 3'd1}, 1'b1, {1'b0, 2'd2});
    enter_digit(3'd0);
    enter_digit(3'd0);
    check("pre_reset_entry", {29'd0, entry_count}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_entry",  {29'd0, entry_count}, 32'd0);
    check("async_rst_tries",  {30'd0, tries_left},  32'd3);
    check("async_rst_ready",  {31'd0, ready},       32'd1);
    check("async_rst_state",  {30'd0, dbg_state},   32'd0);
    check("async_rst_pulses", {30'd0, match, fail}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enter_digit(3'd0);
      check("post_rst_entry", {29'd0, entry_count}, 32'd0);
      check("post_rst_state", {30'd0, dbg_state},  32'd0);
    end
    load4({3'd3, 3'd4, 3'd5, 3'd6});
    enter4({3'd3, 3'd4, 3'd5, 3'd6}, 1'b1, {1'b1, 2'd3});

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
